// File: rtl/alu_pkg.sv
// alu_pkg: constants and state type shared by the ALU shift path.
`default_nettype none

package alu_pkg;
  localparam int WIDTH = 32;
  localparam int AMT_W = $clog2(WIDTH);
  localparam int CNT_W = 3;

  localparam logic DIR_SLL = 1'b0;
  localparam logic DIR_SRA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;
endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
// shift_stage: one combinational log-shifter stage, shifts by 2^stage when enabled.
`default_nettype none

module shift_stage
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] i_data,
  input  logic [CNT_W-1:0] i_stage,
  input  logic             i_en,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_data
);

  logic [7:0] w_dist;

  assign w_dist = 8'd1 << i_stage;

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      if (i_dir == DIR_SRA) begin
        o_data = $unsigned($signed(i_data) >>> w_dist);
      end else begin
        o_data = i_data << w_dist;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_seq.sv
// shift_seq: iterative sll/sra shifter, one log stage per clock behind a start/done handshake.
`default_nettype none

module shift_seq
  import alu_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amt,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  shift_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_amt;
  logic             r_dir;
  logic [WIDTH-1:0] r_out;

  logic [WIDTH-1:0] w_stage_out;
  logic             w_en;
  logic             w_last;

  assign w_en   = r_amt[r_cnt];
  assign w_last = (r_cnt == CNT_W'(AMT_W - 1));

  // Single stage instance reused every cycle; the counter selects the distance.
  shift_stage u_stage (
    .i_data  (r_work),
    .i_stage (r_cnt),
    .i_en    (w_en),
    .i_dir   (r_dir),
    .o_data  (w_stage_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_amt   <= '0;
      r_dir   <= 1'b0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_work  <= in;
            r_amt   <= amt;
            r_dir   <= dir;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_work <= w_stage_out;
          r_cnt  <= r_cnt + 3'd1;
          if (w_last) begin
            r_out   <= w_stage_out;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out  = r_out;
  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_seq.sv
// tb_shift_seq: vector table, random ops against a reference model, and multi-cycle corner sequences.
`default_nettype none

module tb_shift_seq;
  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] in;
  logic [4:0]  amt;
  logic        dir;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  shift_seq dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .in      (in),
    .amt     (amt),
    .dir     (dir),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] vin;
    logic [4:0]  vamt;
    logic        vdir;
    logic [31:0] vexp;
  } vec_t;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s, input logic d);
    logic signed [31:0] sa;
    sa = a;
    if (d) return 32'(sa >>> s);
    return a << s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Issue one op with a start pulse, scramble inputs mid-flight, check latency, busy span and result.
  task automatic run_op(input string name, input logic [31:0] a, input logic [4:0] s,
                        input logic d, input logic [31:0] exp);
    int n;
    int busy_cnt;
    in = a; amt = s; dir = d; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    in = $urandom; amt = 5'($urandom); dir = 1'($urandom);
    n = 0; busy_cnt = 0;
    while (n < 12) begin
      if (busy) busy_cnt++;
      if (done) break;
      @(posedge clock); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd5);
    chk({name, "_busycyc"}, 32'(busy_cnt), 32'd5);
    chk({name, "_out"}, out, exp);
    @(posedge clock); #1;
    chk({name, "_donefall"}, {31'd0, done}, 32'd0);
    chk({name, "_hold"}, out, exp);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h02E04608, 5'd7,  1'b0, 32'h70230400};
    vecs[1] = '{32'h02E04608, 5'd3,  1'b1, 32'h005C08C1};
    vecs[2] = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF};
    vecs[3] = '{32'hDEADBEEF, 5'd0,  1'b0, 32'hDEADBEEF};
    vecs[4] = '{32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF};
    vecs[5] = '{32'h00000001, 5'd31, 1'b0, 32'h80000000};
    vecs[6] = '{32'h7FFFFFFF, 5'd16, 1'b1, 32'h00007FFF};

    reset_n = 1'b0; start = 1'b0; in = '0; amt = '0; dir = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out",  out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].vin, vecs[i].vamt, vecs[i].vdir, vecs[i].vexp);
    end

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      logic [4:0]  s;
      logic        d;
      a = $urandom; s = 5'($urandom); d = 1'($urandom);
      run_op($sformatf("rnd%0d", i), a, s, d, model(a, s, d));
    end

    // start held high: accepts only every 6th edge, each result from its own captured operands
    begin
      logic [31:0] cap_a;
      logic [4:0]  cap_s;
      logic        cap_d;
      cap_a = '0; cap_s = '0; cap_d = 1'b0;
      start = 1'b1;
      for (int e = 0; e < 24; e++) begin
        in = $urandom; amt = 5'($urandom); dir = 1'($urandom);
        if (e % 6 == 0) begin
          cap_a = in; cap_s = amt; cap_d = dir;
        end
        @(posedge clock); #1;
        if (e % 6 == 5) begin
          chk($sformatf("b2b_done_e%0d", e), {31'd0, done}, 32'd1);
          chk($sformatf("b2b_out_e%0d", e), out, model(cap_a, cap_s, cap_d));
        end else begin
          chk($sformatf("b2b_nodone_e%0d", e), {31'd0, done}, 32'd0);
        end
      end
      start = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
    end

    // asynchronous reset during an operation
    begin
      int seen;
      seen = 0;
      in = 32'h12345678; amt = 5'd9; dir = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_out",  out, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      repeat (4) begin
        @(posedge clock); #1;
        if (done) seen++;
      end
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) begin
        @(posedge clock); #1;
        if (done) seen++;
      end
      chk("arst_nodone", 32'(seen), 32'd0);
      chk("arst_outhold", out, 32'd0);
      run_op("post_rst", 32'h0000000F, 5'd4, 1'b0, 32'h000000F0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_seq.md
# shift_seq

Sequential log shifter for the ALU's shift path: left-logical (`sll`) plus the arithmetic-right (`sra`) direction, one log stage per clock. It replaces a single-cycle 32-bit barrel shift with a 5-stage iterative datapath behind a start/done handshake, so the shift path no longer sets the ALU critical path. The multicycle-op controller drives `start` and waits for `done`.

## Interface
- `WIDTH`, 32: operand/result width; must be a power of two.
- `AMT_W`, `$clog2(WIDTH)` = 5: shift-amount width and number of stages.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when not busy.
- `in`  in  WIDTH  operand.
- `amt`  in  AMT_W  shift amount, unsigned 0..31.
- `dir`  in  1  0 = `sll` (zero fill from LSB), 1 = `sra` (sign fill from MSB).
- `out`  out  WIDTH  registered result; holds until the next completion.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when `out` has just been updated.

## Operation
- States: `IDLE`, `SHIFT`, `DONE`.
- `IDLE`/`DONE` with `start`=1:
  - Capture `in` into the work register, and `amt` and `dir` into holding registers.
  - Set stage counter to 0 and go to `SHIFT`.
- `SHIFT`, each edge:
  - Apply stage k = counter: if `amt_q[k]`, shift the work register by 2^k in direction `dir_q`, otherwise pass it through.
  - Increment the counter.
- After stage AMT_W−1:
  - Load the work register result into `out`.
  - Go to `DONE`.
- `DONE`: lasts exactly one cycle. Return to `IDLE`, or back to `SHIFT` if `start` is 1.
- `sll` fill is 0. `sra` fill is bit WIDTH−1 of the captured operand; the work register preserves its MSB across stages.
- Result width is WIDTH; bits shifted out are discarded, with no overflow flag.
- `amt`=0 still takes the full latency, and `out` equals `in`.
- `start` in `SHIFT` is ignored: no queueing, no abort.
- Input changes after capture have no effect on the in-flight operation.

## Timing
- Reset values:
  - `out` = 0, `busy` = 0, `done` = 0.
  - State `IDLE`, counter 0; work and holding registers 0.
- Reset asserted mid-operation: abandon the operation immediately (asynchronous). No `done` is produced. `out` reads 0.
- Edge 0 samples `start`.
- `busy` = 1 from after edge 0 through edge 5. It is combinationally equal to (state == `SHIFT`) and never glitches in `DONE`.
- Edges 1..5 apply stages 0..4.
- At edge 5, `out` updates and `done` rises; `done` falls at edge 6.
- Latency is 5 cycles from the accepting edge to the `out`/`done` edge.
- Back-to-back: a `start` sampled at edge 5 is not accepted, because the state is still `SHIFT` there. A `start` sampled at edge 6 (state `DONE`) is accepted. Maximum throughput is one op per 6 cycles.
- `out` is stable from `done` until the next completion; the consumer may sample it any time after `done`.

## Structure
- Shared package `alu_pkg`:
  - Constants `WIDTH`, `AMT_W`.
  - `DIR_SLL` = 0 and `DIR_SRA` = 1.
  - State enum `shift_state_t` {`IDLE`, `SHIFT`, `DONE`}.
- Sub-module `shift_stage`: combinational. Inputs `data`, `stage` index, `en`, `dir`; output is `data` shifted by 2^stage when `en` is set. Instantiated once and reused every cycle, with no unrolled copies.
- Top holds the FSM, the 3-bit counter, the work/holding registers and the `out` register.

## Test plan
- `in`=0x02E04608, `amt`=7, `dir`=0, `start` pulse → `done` 5 cycles later; `out`=0x70230400; `busy` high for exactly 5 cycles.
- `in`=0x02E04608, `amt`=3, `dir`=1 → `out`=0x005C08C1. Then `in`=0x80000000, `amt`=31, `dir`=1 → `out`=0xFFFFFFFF.
- `in`=0xDEADBEEF, `amt`=0, each `dir` → `out`=0xDEADBEEF after the full 5-cycle latency. `in`=0x00000001, `amt`=31, `dir`=0 → 0x80000000.
- `start` held high continuously with changing operands:
  - Ops are accepted only at edges 0, 6, 12, ….
  - Each `out` matches the operands captured at its own accepting edge.
  - Inputs changed mid-op are ignored.
- `reset_n` low at edge 3 of an op → `out`/`busy`/`done` go to 0 immediately with no `done`. After release, a new op (0x0000000F, `amt` 4, `sll`) gives 0x000000F0.
